// File: rtl/ingress_port_buf.sv
// ingress_port_buf: per-input-port FIFO feeding the output mux controller.
// Tags each word with its destination, pops on winning grant, and reports HOL stall and drops.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module ingress_port_buf #(
  parameter int PORT_ID = 0,
  parameter int DEPTH = 4,
  parameter int STALL_LIMIT = 15,
  localparam int N = `PORT_NUB_TOTAL,
  localparam int WS = $clog2(N),
  localparam int DW = `DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WS-1:0]        in_dest,
  input  logic [DW-1:0]        in_data,
  output logic [N-1:0]         port_vaild,
  input  logic [N-1:0]         wr_en_in,
  input  logic [WS*N-1:0]      mux_sel_in,
  output logic [2*WS+DW-1:0]   data_out,
  output logic                 hol_stall,
  output logic [7:0]           drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [WS-1:0] r_dest [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_stall_cnt, r_drop_cnt;
  logic          r_hol_stall;
  logic          w_head_valid, w_push, w_store, w_grant;
  logic [WS-1:0] w_hd, w_sel;
  logic [7:0]    w_stall_nxt;
  assign w_head_valid = r_count != '0;
  assign w_hd         = r_dest[r_rd_ptr];
  assign w_sel        = mux_sel_in[w_hd*WS +: WS];
  assign w_grant      = w_head_valid & wr_en_in[w_hd] & (w_sel == WS'(PORT_ID));
  assign in_ready     = r_count != (AW+1)'(DEPTH);
  assign w_push       = in_valid & in_ready;
  // destinations past N only exist when N is not a power of two; those words are dropped
  assign w_store      = w_push & ({1'b0, in_dest} < (WS+1)'(N));
  assign w_stall_nxt  = (!w_head_valid || w_grant) ? 8'd0 :
                        (r_stall_cnt == 8'hFF) ? r_stall_cnt : r_stall_cnt + 8'd1;
  assign port_vaild   = w_head_valid ? N'(1) << w_hd : '0;
  assign data_out     = {WS'(PORT_ID), w_hd, r_data[r_rd_ptr]};
  assign hol_stall    = r_hol_stall;
  assign drop_cnt     = r_drop_cnt;
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_dest[r_wr_ptr] <= in_dest;
      r_data[r_wr_ptr] <= in_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
      r_hol_stall <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + AW'(w_store);
      r_rd_ptr    <= r_rd_ptr + AW'(w_grant);
      r_count     <= r_count + (AW+1)'(w_store) - (AW+1)'(w_grant);
      r_stall_cnt <= w_stall_nxt;
      r_hol_stall <= w_stall_nxt >= 8'(STALL_LIMIT);
      if (w_push && !w_store && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_ingress_port_buf.sv
// tb_ingress_port_buf: directed + random traffic against a queue-based reference model.
module tb_ingress_port_buf;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic       in_ready, hol_stall;
  logic [1:0] in_dest = '0;
  logic [7:0] in_data = '0, mux_sel_in = '0, drop_cnt;
  logic [3:0] port_vaild, wr_en_in = '0;
  logic [11:0] data_out;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [1:0] dest; logic [7:0] data;} word_t;
  word_t exp_q[$];
  int m_stall = 0, m_drop = 0;

  ingress_port_buf #(.PORT_ID(1), .DEPTH(4), .STALL_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .port_vaild(port_vaild),
    .wr_en_in(wr_en_in), .mux_sel_in(mux_sel_in), .data_out(data_out),
    .hol_stall(hol_stall), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard/monitor: compares outputs against model state, then advances the model
  always @(negedge clk) begin
    word_t h;
    logic g, p;
    h = exp_q.size() != 0 ? exp_q[0] : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() != 4));
    chk("port_vaild", 32'(port_vaild), exp_q.size() == 0 ? 32'd0 : 32'd1 << h.dest);
    if (exp_q.size() != 0) chk("head_word", 32'(data_out), 32'({2'd1, h.dest, h.data}));
    chk("hol_stall", 32'(hol_stall), 32'(m_stall >= 15));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    g = exp_q.size() != 0 && wr_en_in[h.dest] && mux_sel_in[h.dest*2 +: 2] == 2'd1;
    p = in_valid && exp_q.size() != 4;
    if (!rst_n) begin
      exp_q.delete();
      m_stall = 0;
      m_drop = 0;
    end else begin
      m_stall = (exp_q.size() == 0 || g) ? 0 : (m_stall < 255 ? m_stall + 1 : 255);
      if (g) begin
        chk("granted_word", 32'(data_out), 32'({2'd1, h.dest, h.data}));
        void'(exp_q.pop_front());
      end
      if (p) exp_q.push_back('{dest: in_dest, data: in_data});
    end
  end

  task automatic cyc(input logic v, input logic [1:0] d, input logic [7:0] x,
                     input logic [3:0] w, input logic [7:0] s);
    in_valid = v; in_dest = d; in_data = x; wr_en_in = w; mux_sel_in = s;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [3:0] w, input logic [7:0] s);
    rst_n = 1'b0;
    cyc(1'b0, 2'd0, 8'd0, w, s);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] s;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 2, 8'hA5, 4'b0000, 8'h00);
    cyc(0, 0, 8'h00, 4'b0100, 8'b0001_0000);
    cyc(0, 0, 8'h00, 4'b0000, 8'h00);
    cyc(1, 3, 8'h3C, 4'b0000, 8'h00);
    repeat (20) cyc(0, 0, 8'h00, 4'hF, 8'b1000_0000);
    cyc(0, 0, 8'h00, 4'b1000, 8'b0100_0000);
    repeat (2) cyc(0, 0, 8'h00, 4'b0000, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1, 2'(i), 8'(8'h10 + i), 4'b0000, 8'h00);
    cyc(1, 0, 8'hEE, 4'b0000, 8'h00);
    repeat (5) cyc(0, 0, 8'h00, 4'hF, 8'h55);
    cyc(1, 1, 8'h21, 4'b0000, 8'h00);
    cyc(1, 3, 8'h22, 4'b0000, 8'h00);
    for (int i = 0; i < 8; i++) cyc(1, 2'($urandom), 8'(8'h30 + i), 4'hF, 8'h55);
    repeat (3) cyc(0, 0, 8'h00, 4'hF, 8'h55);
    for (int i = 0; i < 3; i++) cyc(1, 2'(i + 1), 8'(8'h40 + i), 4'b0000, 8'h00);
    do_reset(4'hF, 8'h55);
    repeat (2) cyc(0, 0, 8'h00, 4'b0000, 8'h00);
    cyc(1, 1, 8'h5A, 4'b0000, 8'h00);
    repeat (18) cyc(0, 0, 8'h00, 4'b0000, 8'h55);
    cyc(0, 0, 8'h00, 4'hF, 8'h55);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) s[i*2 +: 2] = ($urandom_range(0, 9) < 6) ? 2'd1 : 2'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset(4'($urandom), s);
      else if (c % 500 < 60) cyc(1'($urandom), 2'($urandom), 8'($urandom), 4'b0000, s);
      else cyc(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom), s);
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
